// File: rtl/pmem_burst_responder_pkg.sv
// Shared types and widths for the 64-bit, 4-beat physical-memory burst
// responder and its line store.
//
// Contents:
//   BEAT_W, LINE_W, BEATS, OFFSET_BITS : burst geometry
//   pmem_state_t                       : responder FSM states
//   pmem_op_t                          : latched burst direction
package pmem_burst_types;

    localparam int BEAT_W      = 64;
    localparam int LINE_W      = 256;
    localparam int BEATS       = 4;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } pmem_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } pmem_op_t;

endpackage

// File: rtl/pmem_burst_responder_line_array.sv
// Line store for the burst responder: 2^INDEX_BITS lines of 256 bits.
// Contents are intentionally not reset.
//
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   full-line write enable
//   waddr  in   line index to write
//   wline  in   256-bit line to write
//   raddr  in   line index to read (combinational)
//   rline  out  256-bit line at raddr
module pmem_line_array
    import pmem_burst_types::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] waddr,
    input  logic [LINE_W-1:0]     wline,
    input  logic [INDEX_BITS-1:0] raddr,
    output logic [LINE_W-1:0]     rline
);

    logic [LINE_W-1:0] mem [2**INDEX_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wline;
        end
    end

    assign rline = mem[raddr];

endmodule

// File: rtl/pmem_burst_responder.sv
// Memory-side responder for the 4-beat, 64-bit physical-memory burst
// protocol. A request seen in IDLE waits LATENCY cycles, then returns
// (read) or absorbs (write) four consecutive beats, then spends one
// turnaround cycle in DONE. Write beats are assembled in a buffer and
// committed to the line store as one full line on the final beat edge.
//
// Handshake: pmem_read/pmem_write are levels held by the initiator until
// the last beat; pmem_resp is the per-beat strobe, high for exactly four
// consecutive cycles. Write data is sampled, and read data is valid, in
// each cycle pmem_resp is high. There is no backpressure on beats.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pmem_read/write     burst request levels
//   pmem_address        line address, bits [4:0] ignored
//   pmem_wdata          write beat
//   pmem_resp           beat strobe (registered)
//   pmem_rdata          read beat (registered, zero outside read beats)
//   read_count          completed read bursts
//   write_count         completed write bursts
//   proto_error         sticky protocol-violation flag
module pmem_burst_responder
    import pmem_burst_types::*;
#(
    parameter int LATENCY    = 8,
    parameter int INDEX_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [BEAT_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [BEAT_W-1:0] pmem_rdata,
    output logic [31:0]       read_count,
    output logic [31:0]       write_count,
    output logic              proto_error
);

    localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

    // FSM state, visible by name for checkers.
    pmem_state_t state, state_d;

    pmem_op_t                        op_q, op_d;
    logic [INDEX_BITS-1:0]           idx_q, idx_d;
    logic [7:0]                      lat_cnt, lat_d;
    logic [1:0]                      beat, beat_d;
    logic [BEATS-1:0][BEAT_W-1:0]    wbuf, wbuf_d;

    logic                            resp_d;
    logic [BEAT_W-1:0]               rdata_d;
    logic [31:0]                     rcnt_d, wcnt_d;
    logic                            perr_d;

    logic [INDEX_BITS-1:0]           req_idx;
    logic [INDEX_BITS-1:0]           rd_idx;
    logic [BEATS-1:0][BEAT_W-1:0]    rd_line;
    logic                            mem_we;
    logic [LINE_W-1:0]               mem_wline;
    logic [1:0]                      beat_nxt;

    assign req_idx  = pmem_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    // In IDLE the index is not yet latched; with LATENCY=1 beat 0 is
    // loaded on the accepting edge, so read straight from the request.
    assign rd_idx   = (state == IDLE) ? req_idx : idx_q;
    assign beat_nxt = beat + 2'd1;
    // Lane 3 comes from the wire on the final edge, not from the buffer.
    assign mem_wline = {pmem_wdata, wbuf[2], wbuf[1], wbuf[0]};

    pmem_line_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_q),
        .wline (mem_wline),
        .raddr (rd_idx),
        .rline (rd_line)
    );

    always_comb begin
        state_d = state;
        op_d    = op_q;
        idx_d   = idx_q;
        lat_d   = lat_cnt;
        beat_d  = beat;
        wbuf_d  = wbuf;
        resp_d  = 1'b0;
        rdata_d = '0;
        rcnt_d  = read_count;
        wcnt_d  = write_count;
        perr_d  = proto_error;
        mem_we  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    // Read wins a simultaneous request.
                    op_d   = pmem_read ? OP_READ : OP_WRITE;
                    idx_d  = req_idx;
                    beat_d = 2'd0;
                    wbuf_d = '0;
                    if (pmem_read && pmem_write) begin
                        perr_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d = BURST;
                        resp_d  = 1'b1;
                        if (pmem_read) begin
                            rdata_d = rd_line[0];
                        end
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_INIT;
                    end
                end
            end

            WAIT: begin
                if (!(pmem_read || pmem_write)) begin
                    state_d = IDLE;
                    perr_d  = 1'b1;
                    lat_d   = '0;
                end else if (lat_cnt == 8'd1) begin
                    // Counter reaches zero on this edge: first beat is
                    // registered now so resp rises exactly LATENCY cycles
                    // after acceptance.
                    state_d = BURST;
                    lat_d   = '0;
                    beat_d  = 2'd0;
                    resp_d  = 1'b1;
                    if (op_q == OP_READ) begin
                        rdata_d = rd_line[0];
                    end
                end else begin
                    lat_d = lat_cnt - 8'd1;
                end
            end

            BURST: begin
                if (op_q == OP_WRITE) begin
                    wbuf_d[beat] = pmem_wdata;
                end
                if (beat == 2'd3) begin
                    state_d = DONE;
                    if (op_q == OP_WRITE) begin
                        mem_we = 1'b1;
                        wcnt_d = write_count + 32'd1;
                    end else begin
                        rcnt_d = read_count + 32'd1;
                    end
                end else begin
                    beat_d = beat_nxt;
                    resp_d = 1'b1;
                    if (op_q == OP_READ) begin
                        rdata_d = rd_line[beat_nxt];
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            idx_q       <= '0;
            lat_cnt     <= '0;
            beat        <= '0;
            wbuf        <= '0;
            pmem_resp   <= 1'b0;
            pmem_rdata  <= '0;
            read_count  <= '0;
            write_count <= '0;
            proto_error <= 1'b0;
        end else begin
            state       <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            lat_cnt     <= lat_d;
            beat        <= beat_d;
            wbuf        <= wbuf_d;
            pmem_resp   <= resp_d;
            pmem_rdata  <= rdata_d;
            read_count  <= rcnt_d;
            write_count <= wcnt_d;
            proto_error <= perr_d;
        end
    end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Bench for pmem_burst_responder: a table of bursts applied in a loop with a
// line model and an expected-beat queue, plus hand-written sequences for a
// request dropped during the latency wait and reset during a write burst.
module tb_pmem_burst_responder;

    localparam int LAT = 8;
    localparam int IB  = 6;

    logic        clk;
    logic        rst;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;
    logic [31:0] read_count;
    logic [31:0] write_count;
    logic        proto_error;

    pmem_burst_responder #(
        .LATENCY    (LAT),
        .INDEX_BITS (IB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .read_count   (read_count),
        .write_count  (write_count),
        .proto_error  (proto_error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [63:0]  exp_q[$];
    logic [255:0] model [2**IB];
    logic [31:0]  exp_rcnt;
    logic [31:0]  exp_wcnt;
    logic         exp_perr;
    int           n_checks;
    int           n_miss;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wline;
        logic         exp_perr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_read_count"}, 64'(read_count), 64'(exp_rcnt));
        check({tag, "_write_count"}, 64'(write_count), 64'(exp_wcnt));
        check({tag, "_proto_error"}, 64'(proto_error), 64'(exp_perr));
    endtask

    // One complete burst: drives the request, feeds write beats, compares
    // read beats popped from the queue, checks latency and beat count.
    task automatic do_burst(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [255:0] wline);
        int n;
        int beats;
        int first;
        logic [5:0]  idx;
        logic [63:0] e;
        idx = addr[10:5];
        if (rd) begin
            for (int b = 0; b < 4; b++) exp_q.push_back(model[idx][b*64 +: 64]);
        end
        @(posedge clk); #1;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        n = 0;
        beats = 0;
        first = -1;
        while (beats < 4 && n < LAT + 20) begin
            @(posedge clk); #1;
            n++;
            if (pmem_resp) begin
                if (first < 0) first = n;
                if (rd) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                    check("rdata", pmem_rdata, e);
                end else begin
                    pmem_wdata = wline[beats*64 +: 64];
                end
                beats++;
            end else if (first >= 0) begin
                break;
            end
        end
        check("first_beat_latency", 64'(first), 64'(LAT));
        check("beat_count", 64'(beats), 64'd4);
        @(posedge clk); #1;
        check("resp_low_after_burst", 64'(pmem_resp), 64'd0);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_wdata = {$urandom, $urandom};
        if (rd) begin
            exp_rcnt++;
        end else begin
            exp_wcnt++;
            model[idx] = wline;
        end
        if (rd && wr) exp_perr = 1'b1;
        check_status("burst");
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic         ok;
        logic [255:0] old_line;
        logic [255:0] new_line;
        int           beats;
        int           n;

        n_checks = 0;
        n_miss   = 0;
        exp_rcnt = 0;
        exp_wcnt = 0;
        exp_perr = 1'b0;
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        // ---------------- reset and idle ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp", 64'(pmem_resp), 64'd0);
        check("reset_rdata", pmem_rdata, 64'd0);
        check_status("reset");
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (pmem_resp !== 1'b0 || pmem_rdata !== 64'd0 || read_count !== 32'd0 ||
                write_count !== 32'd0 || proto_error !== 1'b0) ok = 1'b0;
        end
        check("idle_20_cycles_quiet", 64'(ok), 64'd1);

        // ---------------- table-driven bursts ----------------
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0040,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, '0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0800, rand_line(), 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, '0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h1234_5660, rand_line(), 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_067F, '0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0040, rand_line(), 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0040, '0, 1'b1};

        for (int v = 0; v < 8; v++) begin
            do_burst(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wline);
            check("vec_proto_error", 64'(proto_error), 64'(vecs[v].exp_perr));
        end

        // ---------------- request dropped in WAIT ----------------
        @(posedge clk); #1;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_0040;
        repeat (3) begin
            @(posedge clk); #1;
        end
        pmem_read = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < LAT + 6; i++) begin
            @(posedge clk); #1;
            if (pmem_resp !== 1'b0) ok = 1'b0;
        end
        check("drop_no_resp", 64'(ok), 64'd1);
        exp_perr = 1'b1;
        check_status("drop");

        // ---------------- reset during write beat 2 ----------------
        old_line = rand_line();
        do_burst(1'b0, 1'b1, 32'h0000_0080, old_line);
        new_line = rand_line();
        @(posedge clk); #1;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0080;
        beats = 0;
        n = 0;
        while (beats < 3 && n < LAT + 20) begin
            @(posedge clk); #1;
            n++;
            if (pmem_resp) begin
                pmem_wdata = new_line[beats*64 +: 64];
                beats++;
            end
        end
        check("reached_beat2", 64'(beats), 64'd3);
        rst = 1'b1;
        #1;
        exp_rcnt = 0;
        exp_wcnt = 0;
        exp_perr = 1'b0;
        check("rst_mid_resp", 64'(pmem_resp), 64'd0);
        check("rst_mid_rdata", pmem_rdata, 64'd0);
        check_status("rst_mid");
        pmem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_burst(1'b1, 1'b0, 32'h0000_0080, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pmem_burst_responder.md
Name: pmem_burst_responder

Overview:
- Memory-side responder for the 64-bit, 4-beat physical-memory burst protocol driven by cacheline_adaptor (pmem_read/pmem_write/pmem_address/pmem_wdata out, pmem_resp/pmem_rdata in).
- Provides a synthesizable, latency-configurable line store.
- Lets the full mp4 memory hierarchy be simulated and FPGA-prototyped without an external DRAM model.
- Also keeps read/write burst statistics for performance analysis.

Parameters:
- LATENCY, 8: cycles from request acceptance to first resp beat; legal range 1..255.
- INDEX_BITS, 6: line-index width; the store holds 2^INDEX_BITS 256-bit lines.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pmem_read  in  1  burst read request; held by initiator until final resp beat.
- pmem_write  in  1  burst write request; held by initiator until final resp beat.
- pmem_address  in  32  line address; bits [4:0] ignored.
- pmem_wdata  in  64  write beat; valid in each cycle pmem_resp=1 during a write burst.
- pmem_resp  out  1  beat strobe, high for exactly 4 consecutive cycles per burst.
- pmem_rdata  out  64  read beat; valid when pmem_resp=1 during a read burst.
- read_count  out  32  completed read bursts.
- write_count  out  32  completed write bursts.
- proto_error  out  1  sticky; set on protocol violation.

Behaviour:
- Reset (async, active-high): state=IDLE; pmem_resp=0, pmem_rdata=0, read_count=0, write_count=0, proto_error=0; beat counter, latency counter and write assembly buffer cleared. Line store contents are not reset.
- Outputs are registered.
- Index = pmem_address[5+INDEX_BITS-1:5]. Higher address bits alias, with wrap-around modulo 2^INDEX_BITS lines.
- States:
  - IDLE: on (read|write), latch op, index and address; lat_cnt=LATENCY-1; go to WAIT (or straight to BURST next cycle if LATENCY=1).
  - WAIT: decrement lat_cnt; at 0 go to BURST with beat=0. If the request deasserts in WAIT, abort to IDLE with no resp, no write and no count change, and set proto_error.
  - BURST: pmem_resp=1 for beats 0..3.
    - Read: pmem_rdata = line[beat*64 +: 64], beat 0 = bits [63:0].
    - Write: pmem_wdata is captured into buffer lane [beat*64 +: 64] on each beat.
    - After beat 3: for a write, commit the full 256-bit buffer to the store in the same edge. Increment the matching counter (wraps at 2^32). Go to DONE.
    - Request inputs are ignored during BURST; a burst always completes.
  - DONE: pmem_resp=0 for one turnaround cycle, then IDLE. The initiator's request is low by then.
- Latency: request first seen high in IDLE at cycle T gives resp high in cycles T+LATENCY .. T+LATENCY+3 and resp low at T+LATENCY+4. The earliest next acceptance is cycle T+LATENCY+5.
- Simultaneous read and write in IDLE: serviced as a read, proto_error set.
- Address or op changing during WAIT/BURST: ignored, because the latched values are used.
- Read-after-write to the same line: the committed data is visible to the next burst; there is no forwarding hazard because of the DONE turnaround.
- Reset mid-burst: the partial write buffer is discarded and the store is unchanged; counters and outputs return to reset values immediately.

Decomposition:
- Package pmem_burst_types:
  - BEAT_W=64, LINE_W=256, BEATS=4, OFFSET_BITS=5.
  - pmem_state_t enum {IDLE, WAIT, BURST, DONE}.
  - pmem_op_t {OP_READ, OP_WRITE}.
- Sub-module pmem_line_array: 2^INDEX_BITS x 256 storage with one combinational read port and one synchronous full-line write port.
- The FSM, counters and beat assembly live in pmem_burst_responder.

Test Plan:
- Reset then idle, no requests, 20 cycles -> pmem_resp=0, pmem_rdata=0, counts 0, proto_error=0 throughout.
- Write then read, LATENCY=8:
  - Write to 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> resp high cycles T+8..T+11; write_count=1.
  - Read of 0x0000_0040 -> same four beats in order; read_count=1.
- Aliasing, INDEX_BITS=6: write 0x0000_0800 (index 0), then read 0x0000_0000 -> returns the written line.
- Read and write asserted together at 0x0000_0040 -> read serviced with the stored data, proto_error=1 and sticky, write_count unchanged.
- Request dropped during WAIT (cycle T+3) -> no resp pulse, counts unchanged, proto_error=1.
- rst asserted during write beat 2 -> outputs zero immediately; a subsequent read of that line returns the pre-write data.
